parity_fifo_v2: RTL

PARITY_FIFO_V2 -- requirements
Module: parity_fifo_v2

---
 rtl/parity_fifo_v2.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/parity_fifo_v2.sv
// First-word-fall-through FIFO that drops pushed words failing an input parity check.
// Define PARITY_FIFO_ERR_CNT_EN to add the saturating dropped-word counter on err_count_o.
module parity_fifo_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic [DATA_WIDTH:0]             push_data_i,
  input  logic                            push_valid_i,
  output logic                            push_grant_o,
  output logic [DATA_WIDTH-1:0]           pop_data_o,
  output logic                            pop_valid_o,
  input  logic                            pop_grant_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            almost_full_o,
  output logic                            parity_err_o
`ifdef PARITY_FIFO_ERR_CNT_EN
  ,
  output logic [15:0]                     err_count_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C       = CNT_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(FIFO_DEPTH - 1);
  localparam logic             ODD_C      = (EVEN_ODD != 0);
  localparam logic             CHECK_C    = (PARITY_BIT != 0);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_parity_err;

  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_parity_err_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_parity_calc;
  logic                  w_corrupt;
  logic                  w_write;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST_C) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  function automatic logic parity_of(input logic [DATA_WIDTH:0] word);
    return ^word;
  endfunction

  assign push_grant_o  = (r_count < DEPTH_C);
  assign pop_valid_o   = (r_count != '0);
  assign pop_data_o    = r_mem[r_rd_ptr];
  assign count_o       = r_count;
  assign almost_full_o = (r_count >= AF_C);
  assign parity_err_o  = r_parity_err;

  assign w_push        = push_valid_i && push_grant_o;
  assign w_pop         = pop_valid_o && pop_grant_i;
  assign w_parity_calc = parity_of(push_data_i);
  assign w_corrupt     = CHECK_C && (w_parity_calc != ODD_C);
  assign w_write       = w_push && !w_corrupt;

  // Next-state for pointers, occupancy and the drop pulse; flush wins over push/pop.
  always_comb begin
    w_wr_ptr_nxt     = r_wr_ptr;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_count_nxt      = r_count;
    w_parity_err_nxt = 1'b0;
    if (flush_i) begin
      w_wr_ptr_nxt     = '0;
      w_rd_ptr_nxt     = '0;
      w_count_nxt      = '0;
      w_parity_err_nxt = 1'b0;
    end else begin
      if (w_write) begin
        w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_write, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
      w_parity_err_nxt = w_push && w_corrupt;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_parity_err <= w_parity_err_nxt;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && w_write) begin
      r_mem[r_wr_ptr] <= push_data_i[DATA_WIDTH-1:0];
    end
  end

`ifdef PARITY_FIFO_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Saturating count of dropped words; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 16'h0000;
    end else if (w_parity_err_nxt && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'h0001;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count_o = r_err_count;
`endif

endmodule
